// File: rtl/prog_loader.sv
// Serial boot loader: frames SYNC/COUNT/words[/CSUM] into instruction memory, then releases cpu_rst.
// Optional checksum byte compiled in with LOADER_CHECKSUM_EN.
module prog_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [6:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    // state | meaning
    // IDLE  | hunting for SYNC 0xA5
    // COUNT | expecting word count
    // HI/LO | collecting instruction word bytes
    // WRITE | one-cycle memory write strobe
    // CSUM  | expecting checksum byte (checksum build only)
    // DONE  | load complete, processor released
    // ERR   | aborted, waiting for a new SYNC
    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        HI,
        LO,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } stateT;

    localparam logic [7:0] SYNC = 8'hA5;

    stateT      state;
    stateT      nextState;
    logic [7:0] wordCnt;
    logic       accept;

    assign accept = rx_valid && rx_ready;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csumAcc;
    logic [7:0] csumNext;
    assign csumNext = csumAcc + rx_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        rx_ready  = 1'b1;
        mem_we    = 1'b0;
        cpu_rst   = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (accept && rx_data == SYNC) nextState = COUNT;
            end
            COUNT: begin
                if (accept) nextState = (rx_data > 8'h80) ? ERR : HI;
            end
            HI: begin
                if (accept) nextState = LO;
            end
            LO: begin
                if (accept) nextState = WRITE;
            end
            WRITE: begin
                rx_ready = 1'b0;
                mem_we   = 1'b1;
                if (wordCnt == 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
                    nextState = CSUM;
`else
                    nextState = DONE;
`endif
                end else begin
                    nextState = HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) nextState = (csumNext == 8'h00) ? DONE : ERR;
            end
`endif
            DONE: begin
                rx_ready = 1'b0;
                cpu_rst  = 1'b0;
                done     = 1'b1;
            end
            ERR: begin
                err = 1'b1;
                if (accept && rx_data == SYNC) nextState = COUNT;
            end
            default: nextState = IDLE;
        endcase
    end

    // COUNT 0x00 encodes a full 128-word image
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wordCnt   <= 8'd0;
            mem_addr  <= 7'd0;
            mem_wdata <= 16'd0;
        end else begin
            case (state)
                COUNT: begin
                    if (accept && rx_data <= 8'h80) begin
                        wordCnt  <= (rx_data == 8'h00) ? 8'd128 : rx_data;
                        mem_addr <= 7'd0;
                    end
                end
                HI: if (accept) mem_wdata[15:8] <= rx_data;
                LO: if (accept) mem_wdata[7:0]  <= rx_data;
                WRITE: begin
                    mem_addr <= mem_addr + 7'd1;
                    wordCnt  <= wordCnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csumAcc <= 8'd0;
        end else if (accept) begin
            case (state)
                IDLE, ERR:           if (rx_data == SYNC) csumAcc <= 8'd0;
                COUNT, HI, LO, CSUM: csumAcc <= csumNext;
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table-driven frames plus hand-written corner sequences.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    prog_loader dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cnt;
        logic [7:0] seed;
        logic       expDone;
        logic       expErr;
    } vecT;

    vecT         vecs[8];
    logic [22:0] expQ[$];
    int          total = 0;
    int          bad = 0;
    bit          simEnd = 1'b0;
    logic [6:0]  expAddr = 7'd0;
    logic [7:0]  runSum = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        int waitN = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && waitN < 50) begin
            @(negedge clk);
            waitN++;
        end
        if (!rx_ready) begin
            check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            runSum   = runSum + b;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendWord(input logic [15:0] w);
        expQ.push_back({expAddr, w});
        expAddr = expAddr + 7'd1;
        sendByte(w[15:8]);
        sendByte(w[7:0]);
    endtask

    task automatic startFrame(input logic [7:0] cnt);
        sendByte(8'hA5);
        runSum  = 8'd0;
        expAddr = 7'd0;
        sendByte(cnt);
    endtask

    task automatic sendCsum();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = 8'h00 - runSum;
        sendByte(c);
`endif
    endtask

    task automatic waitEnd(input string name, input logic expDone, input logic expErr);
        int n = 0;
        while (!(done || err) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, {31'd0, done}, {31'd0, expDone});
        check({name, "_err"}, {31'd0, err}, {31'd0, expErr});
        check({name, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, !expDone});
        check({name, "_pending"}, expQ.size(), 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expAddr = 7'd0;
    endtask

    task automatic loadFrame(input logic [7:0] cnt, input logic [7:0] seed);
        int n;
        logic [7:0] ib;
        n = (cnt == 8'h00) ? 128 : ((cnt > 8'h80) ? 0 : int'(cnt));
        startFrame(cnt);
        for (int i = 0; i < n; i++) begin
            ib = 8'(i);
            sendWord({seed + ib, seed ^ ~ib});
        end
        if (n > 0) sendCsum();
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        vecs[0] = '{8'h01, 8'h10, 1'b1, 1'b0};
        vecs[1] = '{8'h02, 8'h20, 1'b1, 1'b0};
        vecs[2] = '{8'h05, 8'h37, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h41, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 8'h5C, 1'b1, 1'b0};
        vecs[5] = '{8'h81, 8'h00, 1'b0, 1'b1};
        vecs[6] = '{8'hFF, 8'h00, 1'b0, 1'b1};
        vecs[7] = '{8'h90, 8'h00, 1'b0, 1'b1};

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        fork
            begin : monitor
                logic [22:0] e;
                while (!simEnd) begin
                    @(negedge clk);
                    if (!rst && mem_we) begin
                        if (expQ.size() == 0) begin
                            check("we_without_pending", {31'd0, mem_we}, 32'd0);
                        end else begin
                            e = expQ.pop_front();
                            check("wr_addr", {25'd0, mem_addr}, {25'd0, e[22:16]});
                            check("wr_data", {16'd0, mem_wdata}, {16'd0, e[15:0]});
                            check("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
                        end
                    end
                    if (!rst && done) check("cpu_rst_with_done", {31'd0, cpu_rst}, 32'd0);
                end
            end
            begin : stimulus
                idle(3);
                check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
                check("rst_mem_we", {31'd0, mem_we}, 32'd0);
                check("rst_mem_addr", {25'd0, mem_addr}, 32'd0);
                check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
                check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
                check("rst_done", {31'd0, done}, 32'd0);
                check("rst_err", {31'd0, err}, 32'd0);
                rst = 1'b0;

                // two-word reference frame
                startFrame(8'h02);
                sendWord(16'h1234);
                sendWord(16'hABCD);
                sendCsum();
                waitEnd("two_word", 1'b1, 1'b0);

                for (int v = 0; v < 8; v++) begin
                    doReset();
                    loadFrame(vecs[v].cnt, vecs[v].seed);
                    waitEnd($sformatf("vec%0d", v), vecs[v].expDone, vecs[v].expErr);
                    check($sformatf("vec%0d_addr", v), {25'd0, mem_addr}, {25'd0, expAddr});
                end

                // junk before SYNC, rx_valid toggling every other cycle
                doReset();
                sendByte(8'h00); idle(1);
                sendByte(8'hFF); idle(1);
                check("junk_cpu_rst", {31'd0, cpu_rst}, 32'd1);
                check("junk_rx_ready", {31'd0, rx_ready}, 32'd1);
                sendByte(8'hA5); runSum = 8'd0; idle(1);
                sendByte(8'h01); idle(1);
                expQ.push_back({7'd0, 16'h0007});
                expAddr = 7'd1;
                sendByte(8'h00); idle(1);
                sendByte(8'h07); idle(1);
                sendCsum();
                waitEnd("toggle", 1'b1, 1'b0);

                // illegal count, then recovery via new SYNC
                doReset();
                startFrame(8'h90);
                idle(2);
                check("badcnt_err", {31'd0, err}, 32'd1);
                check("badcnt_cpu_rst", {31'd0, cpu_rst}, 32'd1);
                sendByte(8'hA5);
                runSum = 8'd0;
                check("recover_err_clear", {31'd0, err}, 32'd0);
                sendByte(8'h01);
                expAddr = 7'd0;
                sendWord(16'h1122);
                sendCsum();
                waitEnd("recover", 1'b1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
                doReset();
                startFrame(8'h01);
                sendWord(16'h1122);
                sendByte(8'h00);
                waitEnd("bad_csum", 1'b0, 1'b1);
`endif

                // asynchronous reset mid-frame
                doReset();
                startFrame(8'h02);
                sendWord(16'h1234);
                idle(2);
                check("midrst_pre_addr", {25'd0, mem_addr}, 32'd1);
                #2;
                rst = 1'b1;
                #1;
                check("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
                check("midrst_mem_addr", {25'd0, mem_addr}, 32'd0);
                check("midrst_rx_ready", {31'd0, rx_ready}, 32'd1);
                check("midrst_done", {31'd0, done}, 32'd0);
                @(negedge clk);
                rst = 1'b0;
                sendByte(8'h02);
                sendByte(8'h12);
                sendByte(8'h34);
                idle(3);
                check("nosync_pending", expQ.size(), 0);
                check("nosync_addr", {25'd0, mem_addr}, 32'd0);
                startFrame(8'h02);
                sendWord(16'hBEEF);
                sendWord(16'h0102);
                sendCsum();
                waitEnd("after_rst", 1'b1, 1'b0);

                idle(2);
                simEnd = 1'b1;
            end
        join

        check("final_pending", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
